// File: rtl/rename_recovery_ctrl.sv
// rename_recovery_ctrl: sequences branch-mispredict recovery of the rename state
//   clk_i, rst_i             clock, synchronous active-high reset
//   mispredict_*_i           mispredict report from execute (valid, ROB index, correct PC)
//   rob_head_idx_i           ROB index at retire port 0
//   retire_valid_i           per-port retire, contiguous from bit 0
//   table_restore_en_o       restore map table / free list (1-cycle pulse)
//   rob_flush_o              flush ROB, RS and in-flight ops (1-cycle pulse)
//   fetch_redirect_valid_o   redirect fetch (1-cycle pulse) to fetch_redirect_pc_o
//   dispatch_stall_o, busy_o high whenever not idle
//   recovery_count_o         completed recoveries, saturating at SAT_MAX
module rename_recovery_ctrl #(
    parameter int          ROB_SZ      = 32,
    parameter int          ROB_IDX_W   = $clog2(ROB_SZ),
    parameter int          ADDR_W      = 32,
    parameter int          HOLD_CYCLES = 1,
    parameter int          RET_W       = 2,
    parameter logic [15:0] SAT_MAX     = 16'hFFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mispredict_valid_i,
    input  logic [ROB_IDX_W-1:0] mispredict_rob_idx_i,
    input  logic [ADDR_W-1:0]    mispredict_target_i,
    input  logic [ROB_IDX_W-1:0] rob_head_idx_i,
    input  logic [RET_W-1:0]     retire_valid_i,
    output logic                 table_restore_en_o,
    output logic                 rob_flush_o,
    output logic                 fetch_redirect_valid_o,
    output logic [ADDR_W-1:0]    fetch_redirect_pc_o,
    output logic                 dispatch_stall_o,
    output logic                 busy_o,
    output logic [15:0]          recovery_count_o
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, RESTORE, HOLD} state_t;

    state_t               state_q;
    logic [ROB_IDX_W-1:0] pend_idx_q;
    logic [ADDR_W-1:0]    pend_tgt_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [HW-1:0]        hold_q;
    logic [15:0]          cnt_q;
    logic                 pulse_q;
    logic [ROB_IDX_W-1:0] age_pend;
    logic [ROB_IDX_W-1:0] age_new;
    logic [ROB_IDX_W:0]   rc;
    logic                 run;
    logic                 pend_retires;

    // Ages wrap modulo ROB_SZ because the subtraction is truncated to ROB_IDX_W bits.
    assign age_pend = pend_idx_q - rob_head_idx_i;
    assign age_new  = mispredict_rob_idx_i - rob_head_idx_i;

    // Count only the leading run of retiring ports; a gap ends the run.
    always_comb begin
        rc  = '0;
        run = 1'b1;
        for (int i = 0; i < RET_W; i++) begin
            run = run & retire_valid_i[i];
            rc  = rc + {{ROB_IDX_W{1'b0}}, run};
        end
    end

    assign pend_retires = {1'b0, age_pend} < rc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pend_idx_q <= '0;
            pend_tgt_q <= '0;
            pc_q       <= '0;
            hold_q     <= '0;
            cnt_q      <= '0;
            pulse_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mispredict_valid_i) begin
                        pend_idx_q <= mispredict_rob_idx_i;
                        pend_tgt_q <= mispredict_target_i;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mispredict_valid_i && age_new < age_pend) begin
                        pend_idx_q <= mispredict_rob_idx_i;
                        pend_tgt_q <= mispredict_target_i;
                    end
                    // Retire test and redirect PC use the pre-replacement pending branch.
                    if (pend_retires) begin
                        pc_q    <= pend_tgt_q;
                        pulse_q <= 1'b1;
                        state_q <= RESTORE;
                    end
                end
                RESTORE: begin
                    pulse_q <= 1'b0;
                    cnt_q   <= cnt_q == SAT_MAX ? cnt_q : cnt_q + 16'd1;
                    hold_q  <= HW'(HOLD_CYCLES - 1);
                    state_q <= HOLD;
                end
                HOLD: begin
                    hold_q  <= hold_q - HW'(1);
                    state_q <= hold_q == '0 ? IDLE : HOLD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign table_restore_en_o     = pulse_q;
    assign rob_flush_o            = pulse_q;
    assign fetch_redirect_valid_o = pulse_q;
    assign fetch_redirect_pc_o    = pc_q;
    assign dispatch_stall_o       = state_q != IDLE;
    assign busy_o                 = state_q != IDLE;
    assign recovery_count_o       = cnt_q;
endmodule
